// File: rtl/apb_reg_slave.sv
// APB3 completer exposing a read-only status word (reg 0) and NUM_REGS-1 read/write
// control registers, with a fixed number of wait states and PSLVERR on illegal accesses.
module apb_reg_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_psel,
    input  logic                              i_penable,
    input  logic                              i_pwrite,
    input  logic [ADDR_WIDTH-1:0]             i_paddr,
    input  logic [DATA_WIDTH-1:0]             i_pwdata,
    output logic [DATA_WIDTH-1:0]             o_prdata,
    output logic                              o_pready,
    output logic                              o_pslverr,
    input  logic [DATA_WIDTH-1:0]             i_status,
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-2:0]               o_wr_pulse
);

    localparam int LSB  = $clog2(DATA_WIDTH / 8);
    localparam int IDXW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam int NRW  = NUM_REGS - 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);
    localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                state_r, state_nx_s;
    logic [3:0]            cnt_r, cnt_nx_s;
    logic [IDXW-1:0]       idx_r, idx_nx_s;
    logic                  write_r, write_nx_s;
    logic                  err_r, err_nx_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_nx_s;
    logic [DATA_WIDTH-1:0] prdata_r, prdata_nx_s;
    logic                  pready_r, pready_nx_s;
    logic                  pslverr_r, pslverr_nx_s;
    logic                  commit_s;

    // regs_r[i] holds register i+1
    logic [DATA_WIDTH-1:0] regs_r [NRW];
    logic [NRW-1:0]        wr_pulse_r;

    logic [ADDR_WIDTH-1:0] live_idx_s;
    logic                  live_err_s;
    logic [IDXW-1:0]       rd_idx_s;
    logic                  rd_err_s;
    logic                  rd_write_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic [DATA_WIDTH-1:0] rd_arr_s [NUM_REGS];

    assign rd_arr_s[0] = i_status;
    for (genvar g = 0; g < NRW; g++) begin : g_rw
        assign rd_arr_s[g+1]                         = regs_r[g];
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH]    = regs_r[g];
    end

    assign o_prdata   = prdata_r;
    assign o_pready   = pready_r;
    assign o_pslverr  = pslverr_r;
    assign o_wr_pulse = wr_pulse_r;

    // Decode the address currently on the bus: index plus error classification
    always_comb begin
        live_idx_s = i_paddr >> LSB;
        live_err_s = ((i_paddr & ALIGN_MASK) != '0)
                   || ({1'b0, live_idx_s} >= NUM_REGS_W)
                   || (i_pwrite && (live_idx_s == '0));
    end

    // Select read source: live decode when completing straight from IDLE, captured otherwise
    always_comb begin
        if (state_r == ST_IDLE) begin
            rd_idx_s   = live_idx_s[IDXW-1:0];
            rd_err_s   = live_err_s;
            rd_write_s = i_pwrite;
        end else begin
            rd_idx_s   = idx_r;
            rd_err_s   = err_r;
            rd_write_s = write_r;
        end
        if (!rd_err_s && !rd_write_s) begin
            rdata_s = rd_arr_s[rd_idx_s];
        end else begin
            rdata_s = '0;
        end
    end

    // Transfer FSM next-state and registered-output next values
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        idx_nx_s     = idx_r;
        write_nx_s   = write_r;
        err_nx_s     = err_r;
        wdata_nx_s   = wdata_r;
        prdata_nx_s  = prdata_r;
        pready_nx_s  = pready_r;
        pslverr_nx_s = pslverr_r;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_psel && !i_penable) begin
                    state_nx_s = ST_ACCESS;
                    cnt_nx_s   = WAIT_INIT;
                    idx_nx_s   = live_idx_s[IDXW-1:0];
                    write_nx_s = i_pwrite;
                    err_nx_s   = live_err_s;
                    wdata_nx_s = i_pwdata;
                    if (WAIT_INIT == 4'd0) begin
                        pready_nx_s  = 1'b1;
                        prdata_nx_s  = rdata_s;
                        pslverr_nx_s = live_err_s;
                    end else begin
                        pready_nx_s  = 1'b0;
                        prdata_nx_s  = '0;
                        pslverr_nx_s = 1'b0;
                    end
                end else begin
                    pready_nx_s  = 1'b0;
                    prdata_nx_s  = '0;
                    pslverr_nx_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (!i_psel) begin
                    // Requester abandoned the transfer: drop it without committing
                    state_nx_s   = ST_IDLE;
                    cnt_nx_s     = 4'd0;
                    pready_nx_s  = 1'b0;
                    prdata_nx_s  = '0;
                    pslverr_nx_s = 1'b0;
                end else if (pready_r) begin
                    state_nx_s   = ST_IDLE;
                    pready_nx_s  = 1'b0;
                    prdata_nx_s  = '0;
                    pslverr_nx_s = 1'b0;
                    commit_s     = write_r && !err_r && i_penable;
                end else if (cnt_r > 4'd1) begin
                    cnt_nx_s = cnt_r - 4'd1;
                end else begin
                    cnt_nx_s     = 4'd0;
                    pready_nx_s  = 1'b1;
                    prdata_nx_s  = rdata_s;
                    pslverr_nx_s = err_r;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                cnt_nx_s     = 4'd0;
                pready_nx_s  = 1'b0;
                prdata_nx_s  = '0;
                pslverr_nx_s = 1'b0;
            end
        endcase
    end

    // FSM state, captured transfer and APB response registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            idx_r     <= '0;
            write_r   <= 1'b0;
            err_r     <= 1'b0;
            wdata_r   <= '0;
            prdata_r  <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            idx_r     <= idx_nx_s;
            write_r   <= write_nx_s;
            err_r     <= err_nx_s;
            wdata_r   <= wdata_nx_s;
            prdata_r  <= prdata_nx_s;
            pready_r  <= pready_nx_s;
            pslverr_r <= pslverr_nx_s;
        end
    end

    // Control register bank and one-cycle write strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NRW; i++) begin
                regs_r[i] <= '0;
            end
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= '0;
            for (int i = 0; i < NRW; i++) begin
                if (commit_s && (idx_r == IDXW'(i + 1))) begin
                    regs_r[i]     <= wdata_r;
                    wr_pulse_r[i] <= 1'b1;
                end
            end
        end
    end

endmodule
